agc_error_stage: RTL

Upstream feeder for the AGC divider stage. Averages the magnitude of a window of signed ADC samples, forms error = setpoint − average, and presents error (dividend) and setpoint (divisor) with a one-cycle start strobe. It then holds off until the divider reports a valid result, so exactly one division is in flight at a time.

---
 rtl/agc_error_stage_if.sv | 26 ++
 rtl/agc_error_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/agc_error_stage_if.sv
// Sample-in / divider-out bundle for agc_error_stage.
// All data fields carry signed two's-complement values.
interface agc_error_stage_if #(
  parameter int DATA_SIZE = 10
);
  logic [DATA_SIZE-1:0] i_sample;
  logic                 i_sample_valid;
  logic                 o_sample_ready;
  logic [DATA_SIZE-1:0] i_setpoint;
  logic                 i_div_valid;
  logic [DATA_SIZE-1:0] o_error;
  logic [DATA_SIZE-1:0] o_reference;
  logic                 o_start;
  logic                 o_setpoint_err;
  logic                 o_timeout;

  modport slave (
    input  i_sample, i_sample_valid, i_setpoint, i_div_valid,
    output o_sample_ready, o_error, o_reference, o_start, o_setpoint_err, o_timeout
  );

  modport master (
    output i_sample, i_sample_valid, i_setpoint, i_div_valid,
    input  o_sample_ready, o_error, o_reference, o_start, o_setpoint_err, o_timeout
  );
endinterface

// File: rtl/agc_error_stage.sv
// AGC error stage: averages |sample| over a window, issues (setpoint - avg, setpoint)
// to the divider and waits for its result so only one division is ever in flight.
module agc_error_stage #(
  parameter int DATA_SIZE   = 10,
  parameter int WINDOW_LOG2 = 4,
  parameter int TIMEOUT     = 255
) (
  input logic               i_clock,
  input logic               i_reset,
  agc_error_stage_if.slave  bus
);
  localparam int AW = DATA_SIZE + WINDOW_LOG2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_ACCUM, ST_CALC, ST_ISSUE, ST_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [DATA_SIZE-1:0]   error_q, error_d;
  logic [DATA_SIZE-1:0]   ref_q, ref_d;
  logic                   sperr_q, sperr_d;
  logic                   tmo_q, tmo_d;

  logic [DATA_SIZE-1:0]   mag;
  logic [DATA_SIZE-1:0]   avg;
  logic [DATA_SIZE-1:0]   sp;
  logic                   sp_le_zero;
  logic                   ready;

  // Magnitude is held unsigned, so |-2^(DATA_SIZE-1)| fits without overflow.
  assign mag        = bus.i_sample[DATA_SIZE-1] ? (~bus.i_sample + 1'b1) : bus.i_sample;
  assign avg        = acc_q[WINDOW_LOG2 +: DATA_SIZE];
  assign sp         = bus.i_setpoint;
  assign sp_le_zero = sp[DATA_SIZE-1] || (sp == '0);
  assign ready      = (state_q == ST_ACCUM) && !i_reset;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    error_d = error_q;
    ref_d   = ref_q;
    sperr_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (bus.i_sample_valid) begin
          acc_d = acc_q + {{WINDOW_LOG2{1'b0}}, mag};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (sp_le_zero) begin
          sperr_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end else begin
          // A positive setpoint minus avg in 0..2^(DATA_SIZE-1) always fits DATA_SIZE signed.
          error_d = sp - avg;
          ref_d   = sp;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_div_valid) begin
          acc_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = ST_ACCUM;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          timer_d = '0;
          state_d = ST_ACCUM;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      error_q <= '0;
      ref_q   <= '0;
      sperr_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      error_q <= error_d;
      ref_q   <= ref_d;
      sperr_q <= sperr_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.o_sample_ready = ready;
  assign bus.o_error        = error_q;
  assign bus.o_reference    = ref_q;
  assign bus.o_start        = (state_q == ST_ISSUE) && !i_reset;
  assign bus.o_setpoint_err = sperr_q;
  assign bus.o_timeout      = tmo_q;
endmodule
